// File: rtl/reg_file.sv
// reg_file: architectural register file with rename tags, commit bypass and mispredict flush
module reg_file #(
  parameter int ROB_ID_WIDTH = 4,
  parameter int REG_COUNT    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    reset_from_rob_bus,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_rob,
  input  logic [4:0]              rd_from_rob,
  input  logic [31:0]             value_from_rob,
  input  logic                    valid_from_issuer,
  input  logic [4:0]              rd_from_issuer,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_issuer,
  input  logic [4:0]              rs1_from_issuer,
  input  logic [4:0]              rs2_from_issuer,
  output logic [ROB_ID_WIDTH-1:0] qj_to_issuer,
  output logic [31:0]             vj_to_issuer,
  output logic [ROB_ID_WIDTH-1:0] qk_to_issuer,
  output logic [31:0]             vk_to_issuer
);
  logic [31:0]             value [REG_COUNT];
  logic [ROB_ID_WIDTH-1:0] tag   [REG_COUNT];
  logic commit, rename;
  assign commit = dest_from_rob != '0 && rd_from_rob != '0;
  assign rename = valid_from_issuer && rd_from_issuer != '0 && !reset_from_rob_bus;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        value[i] <= '0;
        tag[i]   <= '0;
      end
    end else if (rdy) begin
      for (int i = 0; i < REG_COUNT; i++)
        if (reset_from_rob_bus) tag[i] <= '0;
      if (commit) begin
        value[rd_from_rob] <= value_from_rob;
        if (!reset_from_rob_bus && tag[rd_from_rob] == dest_from_rob) tag[rd_from_rob] <= '0;
      end
      // rename comes last so it overrides the commit's tag clear on the same register
      if (rename) tag[rd_from_issuer] <= dest_from_issuer;
    end
  end
  function automatic logic [ROB_ID_WIDTH+31:0] read_src(input logic [4:0] rs);
    if (rs == '0) return '0;
    if (tag[rs] == '0)
      return {{ROB_ID_WIDTH{1'b0}}, (commit && rd_from_rob == rs) ? value_from_rob : value[rs]};
    if (commit && dest_from_rob == tag[rs]) return {{ROB_ID_WIDTH{1'b0}}, value_from_rob};
    return {tag[rs], 32'd0};
  endfunction
  assign {qj_to_issuer, vj_to_issuer} = read_src(rs1_from_issuer);
  assign {qk_to_issuer, vk_to_issuer} = read_src(rs2_from_issuer);
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: table-driven directed checks of reg_file plus a mid-run reset sequence
module tb_reg_file;
  logic        clk = 0;
  logic        rst, rdy, flush;
  logic [3:0]  dest_rob, dest_iss;
  logic [4:0]  rd_rob, rd_iss, rs1, rs2;
  logic [31:0] val_rob;
  logic        valid_iss;
  logic [3:0]  qj, qk;
  logic [31:0] vj, vk;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  reg_file #(.ROB_ID_WIDTH(4), .REG_COUNT(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .reset_from_rob_bus(flush),
    .dest_from_rob(dest_rob), .rd_from_rob(rd_rob), .value_from_rob(val_rob),
    .valid_from_issuer(valid_iss), .rd_from_issuer(rd_iss), .dest_from_issuer(dest_iss),
    .rs1_from_issuer(rs1), .rs2_from_issuer(rs2),
    .qj_to_issuer(qj), .vj_to_issuer(vj), .qk_to_issuer(qk), .vk_to_issuer(vk)
  );

  typedef struct {
    logic rst, rdy, fl;
    logic [3:0] drob; logic [4:0] rrob; logic [31:0] vrob;
    logic vi; logic [4:0] rdi; logic [3:0] di;
    logic [4:0] rs1, rs2;
    logic ck;
    logic [3:0] eqj; logic [31:0] evj; logic [3:0] eqk; logic [31:0] evk;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, rd_y, fl, input logic [3:0] drob, input logic [4:0] rrob,
                              input logic [31:0] vrob, input logic vi, input logic [4:0] rdi,
                              input logic [3:0] di, input logic [4:0] a, b, input logic ck,
                              input logic [3:0] eqj, input logic [31:0] evj,
                              input logic [3:0] eqk, input logic [31:0] evk);
    vec_t t;
    t.rst = r; t.rdy = rd_y; t.fl = fl; t.drob = drob; t.rrob = rrob; t.vrob = vrob;
    t.vi = vi; t.rdi = rdi; t.di = di; t.rs1 = a; t.rs2 = b; t.ck = ck;
    t.eqj = eqj; t.evj = evj; t.eqk = eqk; t.evk = evk;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst = t.rst; rdy = t.rdy; flush = t.fl;
    dest_rob = t.drob; rd_rob = t.rrob; val_rob = t.vrob;
    valid_iss = t.vi; rd_iss = t.rdi; dest_iss = t.di;
    rs1 = t.rs1; rs2 = t.rs2;
  endtask

  initial begin
    //              rst rdy fl drob rrob vrob          vi rdi di  rs1 rs2 ck  qj vj            qk vk
    tbl.push_back(mk(1, 1, 0, 0, 0, 32'h0,          0, 0, 0,  5,  0, 0,  0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,          1, 5, 3,  5,  0, 1,  0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,          0, 0, 0,  5,  5, 1,  3, 32'h0,        3, 32'h0));
    tbl.push_back(mk(0, 1, 0, 3, 5, 32'h1234,       0, 0, 0,  5,  0, 1,  0, 32'h1234,     0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,          1, 7, 2,  5,  7, 1,  0, 32'h1234,     0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,          1, 7, 4,  0,  7, 1,  0, 32'h0,        2, 32'h0));
    tbl.push_back(mk(0, 1, 0, 2, 7, 32'h9,          0, 0, 0,  7,  0, 1,  4, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,          0, 0, 0,  7,  7, 1,  4, 32'h0,        4, 32'h0));
    tbl.push_back(mk(0, 1, 0, 4, 7, 32'h77,         0, 0, 0,  7,  0, 1,  0, 32'h77,       0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,          1, 8, 1,  7,  8, 1,  0, 32'h77,       0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 1, 8, 32'hAA,         1, 8, 6,  8,  8, 1,  0, 32'hAA,       0, 32'hAA));
    tbl.push_back(mk(0, 1, 0, 7, 3, 32'h33,         1, 3, 2,  8,  3, 1,  6, 32'h0,        0, 32'h33));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,          1, 9, 5,  3,  9, 1,  2, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 32'h80,         1, 10, 3, 9,  1, 1,  5, 32'h0,        0, 32'h80));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,          0, 0, 0,  3,  9, 1,  0, 32'h33,       0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,          1, 8, 6,  1, 10, 1,  0, 32'h80,       0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 5, 0, 32'hFF,         1, 0, 7,  0,  8, 1,  0, 32'h0,        6, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0,          1, 4, 2,  0,  4, 1,  0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,          0, 0, 0,  4,  8, 1,  0, 32'h0,        6, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,          0, 0, 0,  0,  4, 1,  0, 32'h0,        0, 32'h0));

    drive(tbl[0]);
    @(posedge clk); #1;
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      if (tbl[i].ck) begin
        check($sformatf("v%0d qj", i), 32'(qj), 32'(tbl[i].eqj));
        check($sformatf("v%0d vj", i), vj, tbl[i].evj);
        check($sformatf("v%0d qk", i), 32'(qk), 32'(tbl[i].eqk));
        check($sformatf("v%0d vk", i), vk, tbl[i].evk);
      end
      @(posedge clk); #1;
    end

    // mid-run reset: x8 still has pending tag 6, x1 and x7 hold values
    drive(mk(1, 1, 0, 0, 0, 32'h0, 1, 8, 9, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    drive(mk(0, 1, 0, 0, 0, 32'h0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("rst x8 q", 32'(qj), 32'h0);
    check("rst x8 v", vj, 32'h0);
    check("rst x1 q", 32'(qk), 32'h0);
    check("rst x1 v", vk, 32'h0);
    @(posedge clk); #1;
    rs1 = 7; rs2 = 3;
    @(negedge clk);
    check("rst x7 v", vj, 32'h0);
    check("rst x3 v", vk, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
